// File: rtl/maze_game_ctrl_pkg.sv
// Shared encodings for the maze game controller: FSM states, maze colours, level codes.
package maze_game_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PLAY  = 3'd1,
        DEAD  = 3'd2,
        SCARE = 3'd3,
        WIN   = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [7:0] COL_BLACK   = 8'h00;
    localparam logic [7:0] COL_BLUE    = 8'h03;
    localparam logic [7:0] COL_MAGENTA = 8'hE3;

    typedef logic [1:0] level_t;
    localparam level_t LVL_1 = 2'd1;
    localparam level_t LVL_2 = 2'd2;
    localparam level_t LVL_3 = 2'd3;

    localparam logic [2:0] PIX_BLANK = 3'b000;

    // Level 1 exits through a blue goal; the later mazes use magenta.
    function automatic logic [7:0] goal_colour(input level_t lvl);
        return (lvl == LVL_1) ? COL_BLUE : COL_MAGENTA;
    endfunction

endpackage

// File: rtl/maze_game_ctrl_frame_counter.sv
// Frame-tick counter with clear and enable; done fires on the enable that reaches TERM.
module frame_counter #(
    parameter int TERM = 60
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam int W = $clog2(TERM + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) cnt <= '0;
        else if (en)       cnt <= cnt + 1'b1;
    end

    // Combinational so the owner can leave its state on the same edge as the last tick.
    assign done = en && (cnt == W'(TERM - 1));

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game sequencer: level select, per-frame wall/goal sampling under the sprite,
// lives, level advance, scare sequence and win/game-over handling.
module maze_game_ctrl
    import maze_game_ctrl_pkg::*;
#(
    parameter int START_LIVES  = 3,
    parameter int HIT_FRAMES   = 2,
    parameter int DEAD_FRAMES  = 60,
    parameter int SCARE_FRAMES = 120,
    parameter int BOX_R        = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_tick,
    input  logic        bright,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [7:0]  maze_rgb,
    input  logic        start,
    output logic [2:0]  pixel_data,
    output logic        player_home,
    output logic        scare_active,
    output logic [1:0]  lives,
    output logic [2:0]  state
);

    localparam int HW = $clog2(HIT_FRAMES + 1);
    localparam logic [16:0] BR = 17'(BOX_R);

    state_t        st;
    level_t        level;
    logic [HW-1:0] hit_cnt;
    logic          wall_f, goal_f;
    logic          start_q, start_rise;
    logic          in_box;
    logic          dead_done, scare_done;
    logic [16:0]   hc, vc, xc, yc;

    assign state = st;

    // 17-bit math keeps the box test honest at both ends of the 16-bit position range.
    assign hc = {7'd0, hCount};
    assign vc = {7'd0, vCount};
    assign xc = {1'b0, x};
    assign yc = {1'b0, y};
    assign in_box = bright && (hc + BR >= xc) && (hc <= xc + BR)
                           && (vc + BR >= yc) && (vc <= yc + BR);

    assign start_rise = start && !start_q;

    always_ff @(posedge clk) begin
        if (!rst_n) start_q <= 1'b0;
        else        start_q <= start;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || st != PLAY || frame_tick) begin
            wall_f <= 1'b0;
            goal_f <= 1'b0;
        end else if (in_box) begin
            if (maze_rgb == COL_BLACK)          wall_f <= 1'b1;
            if (maze_rgb == goal_colour(level)) goal_f <= 1'b1;
        end
    end

    frame_counter #(.TERM(DEAD_FRAMES)) u_dead_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (st != DEAD),
        .en    (frame_tick && st == DEAD),
        .done  (dead_done)
    );

    frame_counter #(.TERM(SCARE_FRAMES)) u_scare_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (st != SCARE),
        .en    (frame_tick && st == SCARE),
        .done  (scare_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st           <= IDLE;
            level        <= 2'd0;
            lives        <= 2'd0;
            hit_cnt      <= '0;
            pixel_data   <= PIX_BLANK;
            player_home  <= 1'b0;
            scare_active <= 1'b0;
        end else begin
            player_home <= 1'b0;
            case (st)
                IDLE: if (start_rise) begin
                    st          <= PLAY;
                    lives       <= 2'(START_LIVES);
                    level       <= LVL_1;
                    hit_cnt     <= '0;
                    pixel_data  <= {1'b0, LVL_1};
                    player_home <= 1'b1;
                end
                PLAY: if (frame_tick) begin
                    if (goal_f) begin
                        hit_cnt <= '0;
                        if (level != LVL_3) begin
                            level       <= level + 2'd1;
                            pixel_data  <= {1'b0, level + 2'd1};
                            player_home <= 1'b1;
                        end else begin
                            st           <= SCARE;
                            scare_active <= 1'b1;
                            pixel_data   <= {1'b0, LVL_3};
                        end
                    end else if (wall_f) begin
                        if (hit_cnt == HW'(HIT_FRAMES - 1)) begin
                            hit_cnt <= '0;
                            lives   <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                            st      <= DEAD;
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end else begin
                        hit_cnt <= '0;
                    end
                end
                DEAD: if (dead_done) begin
                    if (lives == 2'd0) begin
                        st         <= OVER;
                        pixel_data <= PIX_BLANK;
                    end else begin
                        st          <= PLAY;
                        player_home <= 1'b1;
                    end
                end
                SCARE: if (scare_done) begin
                    st           <= WIN;
                    scare_active <= 1'b0;
                    pixel_data   <= PIX_BLANK;
                end
                WIN, OVER: if (start_rise) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Bench for maze_game_ctrl: box-boundary vector table, scripted game scenarios and
// random play checked against an event-level game model.
module tb_maze_game_ctrl;
    import maze_game_ctrl_pkg::*;

    localparam int START_LIVES  = 3;
    localparam int HIT_FRAMES   = 2;
    localparam int DEAD_FRAMES  = 60;
    localparam int SCARE_FRAMES = 120;
    localparam int BOX_R        = 5;

    logic        clk = 1'b0, rst_n = 1'b0, frame_tick = 1'b0, bright = 1'b0, start = 1'b0;
    logic [9:0]  hCount = '0, vCount = '0;
    logic [15:0] x = '0, y = '0;
    logic [7:0]  maze_rgb = '0;
    logic [2:0]  pixel_data, state;
    logic        player_home, scare_active;
    logic [1:0]  lives;

    maze_game_ctrl #(
        .START_LIVES(START_LIVES), .HIT_FRAMES(HIT_FRAMES), .DEAD_FRAMES(DEAD_FRAMES),
        .SCARE_FRAMES(SCARE_FRAMES), .BOX_R(BOX_R)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .bright(bright),
        .hCount(hCount), .vCount(vCount), .x(x), .y(y), .maze_rgb(maze_rgb),
        .start(start), .pixel_data(pixel_data), .player_home(player_home),
        .scare_active(scare_active), .lives(lives), .state(state)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, homes_seen = 0;
    always @(negedge clk) if (player_home === 1'b1) homes_seen++;

    // Game model: one step per clock, reasoning in game events rather than hardware.
    state_t m_st = IDLE;
    int  m_lives = 0, m_level = 0, m_streak = 0, m_frames = 0, m_homes = 0;
    bit  m_wall = 0, m_goal = 0, m_start_q = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int homes_now();
        return homes_seen + ((player_home === 1'b1) ? 1 : 0);
    endfunction

    function automatic bit m_inbox(input bit br, input int h, input int v);
        int xi = int'(x), yi = int'(y);
        return br && (h + BOX_R >= xi) && (h <= xi + BOX_R) && (v + BOX_R >= yi) && (v <= yi + BOX_R);
    endfunction

    function automatic int m_pix();
        case (m_st)
            PLAY, DEAD: return m_level;
            SCARE:      return 3;
            default:    return 0;
        endcase
    endfunction

    task automatic m_step(input bit ft, input bit br, input int h, input int v,
                          input logic [7:0] rgb, input bit st_in);
        bit rise = st_in && !m_start_q;
        m_start_q = st_in;
        case (m_st)
            IDLE: if (rise) begin
                m_st = PLAY; m_lives = START_LIVES; m_level = 1; m_streak = 0; m_homes++;
            end
            PLAY: if (ft) begin
                if (m_goal) begin
                    m_streak = 0;
                    if (m_level < 3) begin m_level++; m_homes++; end
                    else begin m_st = SCARE; m_frames = 0; end
                end else if (m_wall) begin
                    m_streak++;
                    if (m_streak >= HIT_FRAMES) begin
                        m_streak = 0; m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                        m_st = DEAD; m_frames = 0;
                    end
                end else m_streak = 0;
                m_wall = 0; m_goal = 0;
            end else if (m_inbox(br, h, v)) begin
                if (rgb == 8'h00) m_wall = 1;
                if (rgb == ((m_level == 1) ? 8'h03 : 8'hE3)) m_goal = 1;
            end
            DEAD: if (ft) begin
                m_frames++;
                if (m_frames == DEAD_FRAMES) begin
                    if (m_lives == 0) m_st = OVER;
                    else begin m_st = PLAY; m_homes++; end
                end
            end
            SCARE: if (ft) begin
                m_frames++;
                if (m_frames == SCARE_FRAMES) m_st = WIN;
            end
            default: if (rise) m_st = IDLE;
        endcase
    endtask

    task automatic compare_all(input string tag);
        chk({tag, "_state"}, state, m_st);
        chk({tag, "_pix"}, pixel_data, m_pix());
        chk({tag, "_lives"}, lives, m_lives);
        chk({tag, "_scare"}, scare_active, (m_st == SCARE) ? 1 : 0);
        chk({tag, "_homes"}, homes_now(), m_homes);
    endtask

    task automatic cyc(input bit ft, input bit br, input int h, input int v,
                       input logic [7:0] rgb, input bit st_in, input string tag);
        @(negedge clk);
        frame_tick = ft; bright = br; hCount = 10'(h); vCount = 10'(v);
        maze_rgb = rgb; start = st_in;
        @(posedge clk); #1;
        m_step(ft, br, h, v, rgb, st_in);
        compare_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0; frame_tick = 1'b0; bright = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        m_st = IDLE; m_lives = 0; m_level = 0; m_streak = 0; m_frames = 0;
        m_wall = 0; m_goal = 0; m_start_q = 0;
        compare_all(tag);
        rst_n = 1'b1;
    endtask

    task automatic press(input string tag);
        cyc(0, 0, 0, 0, 8'h00, 1, tag);
        cyc(0, 0, 0, 0, 8'h00, 0, tag);
    endtask

    task automatic pix(input logic [7:0] rgb, input string tag);
        cyc(0, 1, int'(x), int'(y), rgb, 0, tag);
    endtask

    task automatic tick(input string tag);
        cyc(1, 0, 0, 0, 8'h00, 0, tag);
    endtask

    task automatic frame(input logic [7:0] rgb, input string tag);
        pix(rgb, tag);
        tick(tag);
    endtask

    typedef struct {
        logic [15:0] vx, vy;
        int          h, v;
        bit          br;
        logic [7:0]  rgb;
        logic [2:0]  exp_pix;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int rv_start;
        int homes0;

        // One blue pixel in level 1 followed by a tick: level 2 only if it was in the box.
        vecs[0]  = '{16'd100,   16'd100, 100,  100, 1'b1, 8'h03, 3'd2};
        vecs[1]  = '{16'd100,   16'd100, 105,  95,  1'b1, 8'h03, 3'd2};
        vecs[2]  = '{16'd100,   16'd100, 106,  100, 1'b1, 8'h03, 3'd1};
        vecs[3]  = '{16'd100,   16'd100, 95,   105, 1'b1, 8'h03, 3'd2};
        vecs[4]  = '{16'd100,   16'd100, 94,   100, 1'b1, 8'h03, 3'd1};
        vecs[5]  = '{16'd100,   16'd100, 100,  106, 1'b1, 8'h03, 3'd1};
        vecs[6]  = '{16'd100,   16'd100, 100,  100, 1'b0, 8'h03, 3'd1};
        vecs[7]  = '{16'd100,   16'd100, 100,  100, 1'b1, 8'hE3, 3'd1};
        vecs[8]  = '{16'd2,     16'd3,   0,    0,   1'b1, 8'h03, 3'd2};
        vecs[9]  = '{16'd65535, 16'd100, 1023, 100, 1'b1, 8'h03, 3'd1};
        vecs[10] = '{16'd1028,  16'd0,   1023, 0,   1'b1, 8'h03, 3'd2};
        vecs[11] = '{16'd0,     16'd0,   5,    5,   1'b1, 8'h03, 3'd2};
        vecs[12] = '{16'd0,     16'd0,   6,    0,   1'b1, 8'h03, 3'd1};
        vecs[13] = '{16'd65534, 16'd65534, 0,  0,   1'b1, 8'h03, 3'd1};

        do_reset("rst0");
        chk("reset_state", state, 3'd0);
        chk("reset_pix", pixel_data, 3'd0);
        chk("reset_lives", lives, 2'd0);
        chk("reset_home", player_home, 1'b0);

        for (int i = 0; i < 14; i++) begin
            do_reset("vec_rst");
            press("vec_start");
            x = vecs[i].vx; y = vecs[i].vy;
            cyc(0, vecs[i].br, vecs[i].h, vecs[i].v, vecs[i].rgb, 0, "vec_pix");
            tick("vec_tick");
            chk($sformatf("vec%0d_pix", i), pixel_data, vecs[i].exp_pix);
        end

        // Game start and level 1 goal.
        do_reset("t1_rst");
        homes0 = homes_now();
        press("t1");
        chk("t1_state", state, 3'd1);
        chk("t1_pix", pixel_data, 3'b001);
        chk("t1_lives", lives, 2'd3);
        chk("t1_home", homes_now() - homes0, 1);
        x = 16'd635; y = 16'd110;
        frame(8'h03, "t2");
        chk("t2_pix", pixel_data, 3'b010);
        chk("t2_home", player_home, 1'b1);

        // Wrong-colour goal in level 2, then wall streak broken by a clean frame.
        frame(8'h03, "t2b");
        chk("t2b_pix", pixel_data, 3'b010);
        frame(8'h00, "t3a");
        chk("t3a_lives", lives, 2'd3);
        frame(8'h55, "t3b");
        frame(8'h00, "t3c");
        chk("t3c_state", state, 3'd1);
        frame(8'h00, "t3d");
        chk("t3d_lives", lives, 2'd2);
        chk("t3d_state", state, 3'd2);
        press("t3_ignored");
        chk("t3_ign_state", state, 3'd2);

        // Burn the remaining lives and reach game over.
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < DEAD_FRAMES; t++) tick("t5_dead");
            chk("t5_back", state, 3'd1);
            frame(8'h00, "t5_w1");
            frame(8'h00, "t5_w2");
        end
        chk("t5_lives0", lives, 2'd0);
        for (int t = 0; t < DEAD_FRAMES - 1; t++) tick("t5_last");
        chk("t5_still_dead", state, 3'd2);
        tick("t5_over");
        chk("t5_over_state", state, 3'd5);
        chk("t5_over_pix", pixel_data, 3'd0);
        press("t5_idle");
        chk("t5_idle_state", state, 3'd0);

        // Goal beats wall in the same frame.
        press("t4_start");
        pix(8'h00, "t4");
        pix(8'h03, "t4");
        tick("t4");
        chk("t4_pix", pixel_data, 3'b010);
        chk("t4_lives", lives, 2'd3);

        // Clear level 2 and 3, then the scare runs exactly SCARE_FRAMES ticks.
        frame(8'hE3, "t6_l2");
        chk("t6_l3", pixel_data, 3'b011);
        frame(8'hE3, "t6_goal");
        chk("t6_scare_state", state, 3'd3);
        for (int t = 0; t < SCARE_FRAMES; t++) begin
            chk("t6_scare_on", scare_active, 1'b1);
            tick("t6_scare");
        end
        chk("t6_win", state, 3'd4);
        chk("t6_scare_off", scare_active, 1'b0);
        press("t6_idle");
        press("t6_restart");
        frame(8'h03, "t6b");
        frame(8'hE3, "t6b");
        frame(8'hE3, "t6b");
        for (int t = 0; t < 10; t++) tick("t6b_scare");
        chk("t6b_mid", scare_active, 1'b1);
        do_reset("t6b_rst");
        chk("t6b_rst_state", state, 3'd0);
        chk("t6b_rst_scare", scare_active, 1'b0);

        // Random play against the model.
        rv_start = 0;
        for (int i = 0; i < 6000; i++) begin
            int r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset("rnd_rst");
                rv_start = 0;
            end else if (r < 60) begin
                rv_start = rv_start ^ 1;
                cyc(0, 0, 0, 0, 8'h00, rv_start[0], "rnd_start");
            end else if (r < 400) begin
                cyc(1, 0, 0, 0, 8'h00, rv_start[0], "rnd_tick");
            end else begin
                int h, v, c;
                logic [7:0] rgb;
                if ($urandom_range(0, 49) == 0) begin
                    x = 16'($urandom_range(0, 700));
                    y = 16'($urandom_range(0, 500));
                end
                h = int'(x) + $urandom_range(0, 14) - 7;
                v = int'(y) + $urandom_range(0, 14) - 7;
                if (h < 0) h = 0;
                if (v < 0) v = 0;
                if (h > 1023) h = 1023;
                if (v > 1023) v = 1023;
                c = $urandom_range(0, 3);
                rgb = (c == 0) ? 8'h00 : (c == 1) ? 8'h03 : (c == 2) ? 8'hE3 : 8'($urandom);
                cyc(0, $urandom_range(0, 7) != 0, h, v, rgb, rv_start[0], "rnd_pix");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
